// File: rtl/quiescence_slot_gate_pkg.sv
// rtl/quiescence_slot_gate_pkg.sv - shared types and constants for the slot quiescence gate
package AOSF1Types;

  typedef enum logic [1:0] {
    QSG_RUNNING  = 2'b00,
    QSG_DRAINING = 2'b01,
    QSG_QUIESCED = 2'b10
  } QSG_STATE;

  localparam int QRESP_QUIESCED_BIT    = 0;
  localparam int QRESP_DRAINING_BIT    = 1;
  localparam int QRESP_TIMEOUT_BIT     = 2;
  localparam int QRESP_UNDERFLOW_BIT   = 3;
  localparam int QRESP_OUTSTANDING_LSB = 16;

  localparam int QUIESCE_CMD_BIT = 0;

  localparam int QSG_DEFAULT_OUTSTANDING_BITS = 8;
  localparam int QSG_DEFAULT_DRAIN_TIMEOUT    = 4096;

  typedef struct packed {
    logic        valid;
    logic        isRequest;
    logic [63:0] data;
  } QuiescenceReq;

  typedef struct packed {
    logic        valid;
    logic [63:0] data;
  } QuiescenceResp;

endpackage

// File: rtl/quiescence_slot_gate_outstanding_counter.sv
// rtl/quiescence_slot_gate_outstanding_counter.sv - saturating in-flight request counter with underflow detect
module quiescence_outstanding_counter #(
  parameter int OUTSTANDING_BITS = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        inc,
  input  logic                        dec,
  output logic [OUTSTANDING_BITS-1:0] count,
  output logic                        is_zero,
  output logic                        is_max,
  output logic                        underflow
);

  always_comb begin
    is_zero   = (count == '0);
    is_max    = &count;
    // A response with nothing in flight is reported rather than wrapping.
    underflow = dec && !inc && is_zero;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !dec && !is_max) begin
      count <= count + 1'b1;
    end else if (dec && !inc && !is_zero) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/quiescence_slot_gate.sv
// rtl/quiescence_slot_gate.sv - per-slot request gate that drains and reports quiescence
module quiescence_slot_gate
  import AOSF1Types::*;
#(
  parameter int OUTSTANDING_BITS = QSG_DEFAULT_OUTSTANDING_BITS,
  parameter int DRAIN_TIMEOUT    = QSG_DEFAULT_DRAIN_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  QuiescenceReq  quiescence_req,
  output QuiescenceResp quiescence_resp,
  input  logic          app_req_valid,
  output logic          app_req_grant,
  output logic          mem_req_valid,
  input  logic          mem_req_grant,
  input  logic          mem_resp_valid,
  output logic          quiesced
);

  localparam int DCW = (DRAIN_TIMEOUT > 0) ? $clog2(DRAIN_TIMEOUT + 1) : 1;
  localparam logic [DCW-1:0] DRAIN_LIMIT = DCW'(DRAIN_TIMEOUT);

  QSG_STATE                    state, state_nxt;
  logic [DCW-1:0]              drain_cnt, drain_cnt_nxt;
  logic                        timeout_flag, timeout_flag_nxt;
  logic                        underflow_err, underflow_err_nxt;
  logic [63:0]                 resp_data, resp_data_nxt;
  logic [OUTSTANDING_BITS-1:0] outstanding;
  logic                        cnt_zero, cnt_max, cnt_underflow;
  logic                        gate_open, accept, cmd_quiesce, cmd_resume;
  logic                        unused_cmd_bits;

  assign unused_cmd_bits = ^quiescence_req.data[63:1];

  always_comb begin
    cmd_quiesce   = quiescence_req.valid && quiescence_req.isRequest &&
                    quiescence_req.data[QUIESCE_CMD_BIT];
    cmd_resume    = quiescence_req.valid && quiescence_req.isRequest &&
                    !quiescence_req.data[QUIESCE_CMD_BIT];
    gate_open     = (state == QSG_RUNNING) && !cnt_max;
    mem_req_valid = gate_open && app_req_valid;
    app_req_grant = mem_req_valid && mem_req_grant;
    accept        = app_req_grant;
    quiesced      = (state == QSG_QUIESCED);
  end

  quiescence_outstanding_counter #(
    .OUTSTANDING_BITS(OUTSTANDING_BITS)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .inc      (accept),
    .dec      (mem_resp_valid),
    .count    (outstanding),
    .is_zero  (cnt_zero),
    .is_max   (cnt_max),
    .underflow(cnt_underflow)
  );

  always_comb begin
    state_nxt         = state;
    drain_cnt_nxt     = drain_cnt;
    timeout_flag_nxt  = timeout_flag;
    underflow_err_nxt = underflow_err;
    if (cmd_resume) begin
      state_nxt         = QSG_RUNNING;
      drain_cnt_nxt     = '0;
      timeout_flag_nxt  = 1'b0;
      underflow_err_nxt = 1'b0;
    end else begin
      case (state)
        QSG_RUNNING: begin
          if (cmd_quiesce) begin
            state_nxt     = QSG_DRAINING;
            drain_cnt_nxt = '0;
          end
        end
        QSG_DRAINING: begin
          if (cnt_zero) begin
            state_nxt = QSG_QUIESCED;
          end else begin
            if (drain_cnt != DRAIN_LIMIT) drain_cnt_nxt = drain_cnt + 1'b1;
            if (DRAIN_TIMEOUT != 0 && drain_cnt_nxt == DRAIN_LIMIT) timeout_flag_nxt = 1'b1;
          end
        end
        QSG_QUIESCED: ;
        default: state_nxt = QSG_RUNNING;
      endcase
    end
    if (cnt_underflow) underflow_err_nxt = 1'b1;
  end

  // Status snapshot is taken from registered values, so it trails the state by one cycle.
  always_comb begin
    resp_data_nxt                                              = '0;
    resp_data_nxt[QRESP_QUIESCED_BIT]                          = (state == QSG_QUIESCED);
    resp_data_nxt[QRESP_DRAINING_BIT]                          = (state == QSG_DRAINING);
    resp_data_nxt[QRESP_TIMEOUT_BIT]                           = timeout_flag;
    resp_data_nxt[QRESP_UNDERFLOW_BIT]                         = underflow_err;
    resp_data_nxt[QRESP_OUTSTANDING_LSB +: OUTSTANDING_BITS]   = outstanding;
    quiescence_resp.valid                                      = 1'b1;
    quiescence_resp.data                                       = resp_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= QSG_RUNNING;
      drain_cnt     <= '0;
      timeout_flag  <= 1'b0;
      underflow_err <= 1'b0;
      resp_data     <= '0;
    end else begin
      state         <= state_nxt;
      drain_cnt     <= drain_cnt_nxt;
      timeout_flag  <= timeout_flag_nxt;
      underflow_err <= underflow_err_nxt;
      resp_data     <= resp_data_nxt;
    end
  end

endmodule

// File: tb/tb_quiescence_slot_gate.sv
// tb/tb_quiescence_slot_gate.sv - self-checking bench for quiescence_slot_gate
module tb_quiescence_slot_gate;
  import AOSF1Types::*;

  localparam int OB   = 2;
  localparam int DT   = 16;
  localparam int MAXO = (1 << OB) - 1;

  logic          clk = 1'b0;
  logic          rst;
  QuiescenceReq  quiescence_req;
  QuiescenceResp quiescence_resp;
  logic          app_req_valid, app_req_grant, mem_req_valid, mem_req_grant;
  logic          mem_resp_valid, quiesced;

  always #5 clk = ~clk;

  quiescence_slot_gate #(.OUTSTANDING_BITS(OB), .DRAIN_TIMEOUT(DT)) dut (
    .clk            (clk),
    .rst            (rst),
    .quiescence_req (quiescence_req),
    .quiescence_resp(quiescence_resp),
    .app_req_valid  (app_req_valid),
    .app_req_grant  (app_req_grant),
    .mem_req_valid  (mem_req_valid),
    .mem_req_grant  (mem_req_grant),
    .mem_resp_valid (mem_resp_valid),
    .quiesced       (quiesced)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: 0=running 1=draining 2=quiesced, plain integer bookkeeping.
  int          m_st = 0, m_out = 0, m_dr = 0;
  bit          m_to = 0, m_uf = 0;
  logic [63:0] m_d = '0;
  bit          cur_rst, cur_rv, cur_isreq, cur_cbit, cur_av, cur_g, cur_resp;

  typedef struct {
    bit          rst, rv, isreq, cbit, av, g, resp;
    bit          e_mrv, e_grant, e_q;
    logic [63:0] e_data;
  } vec_t;
  vec_t tbl[20];

  task automatic check1(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_status();
    logic [63:0] v;
    v = '0;
    v[0] = (m_st == 2);
    v[1] = (m_st == 1);
    v[2] = m_to;
    v[3] = m_uf;
    v = v | (64'(m_out) << 16);
    return v;
  endfunction

  task automatic drive(input bit r, rv, isreq, cbit, av, g, resp);
    cur_rst = r; cur_rv = rv; cur_isreq = isreq; cur_cbit = cbit;
    cur_av = av; cur_g = g; cur_resp = resp;
    rst = r;
    quiescence_req.valid     = rv;
    quiescence_req.isRequest = isreq;
    quiescence_req.data      = {$urandom, $urandom};
    quiescence_req.data[0]   = cbit;
    app_req_valid  = av;
    mem_req_grant  = g;
    mem_resp_valid = resp;
    @(negedge clk);
  endtask

  task automatic check_model();
    bit open, e_mrv;
    open  = (m_st == 0) && (m_out < MAXO);
    e_mrv = open && cur_av;
    check1("mem_req_valid", mem_req_valid, e_mrv);
    check1("app_req_grant", app_req_grant, e_mrv && cur_g);
    check1("quiesced", quiesced, m_st == 2);
    check1("resp_valid", quiescence_resp.valid, 1'b1);
    check1("resp_data", quiescence_resp.data, m_d);
  endtask

  task automatic advance();
    bit open, acc, ufl;
    int nout;
    if (cur_rst) begin
      m_st = 0; m_out = 0; m_dr = 0; m_to = 0; m_uf = 0; m_d = '0;
    end else begin
      m_d  = model_status();
      open = (m_st == 0) && (m_out < MAXO);
      acc  = cur_av && cur_g && open;
      nout = m_out + int'(acc) - int'(cur_resp);
      ufl  = 0;
      if (nout < 0) begin nout = 0; ufl = 1; end
      if (cur_rv && cur_isreq && !cur_cbit) begin
        m_st = 0; m_dr = 0; m_to = 0; m_uf = 0;
      end else if (m_st == 0 && cur_rv && cur_isreq && cur_cbit) begin
        m_st = 1; m_dr = 0;
      end else if (m_st == 1) begin
        if (m_out == 0) m_st = 2;
        else begin
          if (m_dr < DT) m_dr++;
          if (m_dr == DT) m_to = 1;
        end
      end
      if (ufl) m_uf = 1;
      m_out = nout;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit r, rv, isreq, cbit, av, g, resp);
    drive(r, rv, isreq, cbit, av, g, resp);
    check_model();
    advance();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int first_to;
    bit r, rv, isreq, cbit, av, g, resp;

    //          rst rv iq cb av g rs  mrv gnt q  data
    tbl[0]  = '{0, 0, 0, 0, 1, 1, 0,  1, 1, 0, 64'h0};
    tbl[1]  = '{0, 0, 0, 0, 1, 1, 0,  1, 1, 0, 64'h0};
    tbl[2]  = '{0, 0, 0, 0, 1, 1, 0,  1, 1, 0, 64'h10000};
    tbl[3]  = '{0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 64'h20000};
    tbl[4]  = '{0, 0, 0, 0, 1, 1, 1,  0, 0, 0, 64'h30000};
    tbl[5]  = '{0, 0, 0, 0, 1, 1, 0,  1, 1, 0, 64'h30000};
    tbl[6]  = '{0, 1, 1, 1, 0, 0, 0,  0, 0, 0, 64'h20000};
    tbl[7]  = '{0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 64'h30000};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 64'h30002};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 64'h30002};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 64'h20002};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 64'h10002};
    tbl[12] = '{0, 0, 0, 0, 1, 1, 0,  0, 0, 1, 64'h2};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 64'h1};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 64'h1};
    tbl[15] = '{0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 64'h1};
    tbl[16] = '{0, 1, 1, 0, 0, 0, 0,  0, 0, 1, 64'h9};
    tbl[17] = '{0, 0, 0, 0, 1, 0, 0,  1, 0, 0, 64'h9};
    tbl[18] = '{0, 1, 0, 1, 0, 0, 0,  0, 0, 0, 64'h0};
    tbl[19] = '{0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 64'h0};

    drive(1, 0, 0, 0, 0, 0, 0);
    advance();
    step(1, 0, 0, 0, 1, 1, 1);
    check1("reset_data", quiescence_resp.data, 64'h0);
    check1("reset_quiesced", quiesced, 1'b0);

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].rst, tbl[i].rv, tbl[i].isreq, tbl[i].cbit, tbl[i].av, tbl[i].g, tbl[i].resp);
      check1($sformatf("tbl%0d_mem_req_valid", i), mem_req_valid, tbl[i].e_mrv);
      check1($sformatf("tbl%0d_app_req_grant", i), app_req_grant, tbl[i].e_grant);
      check1($sformatf("tbl%0d_quiesced", i), quiesced, tbl[i].e_q);
      check1($sformatf("tbl%0d_resp_data", i), quiescence_resp.data, tbl[i].e_data);
      advance();
    end

    // Quiesce and accept in the same cycle with nothing outstanding.
    drive(0, 1, 1, 1, 1, 1, 0);
    check1("same_cycle_grant", app_req_grant, 1'b1);
    check_model();
    advance();
    idle();
    check1("same_cycle_draining", quiescence_resp.data, 64'h10002);
    for (int i = 0; i < 3; i++) idle();
    check1("same_cycle_waits", quiesced, 1'b0);
    step(0, 0, 0, 0, 0, 0, 1);
    idle();
    check1("same_cycle_quiesced", quiesced, 1'b1);
    step(0, 1, 1, 0, 0, 0, 0);

    // Accept and response together with two outstanding.
    step(0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 1, 1, 1);
    idle();
    check1("acc_resp_balance", quiescence_resp.data, 64'h20000);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // Drain timeout with one request never answered.
    step(0, 0, 0, 0, 1, 1, 0);
    step(0, 1, 1, 1, 0, 0, 0);
    first_to = -1;
    for (int i = 1; i <= 20; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      if (quiescence_resp.data[2] && first_to < 0) first_to = i;
      check_model();
      advance();
    end
    check1("timeout_onset_cycle", first_to, 18);
    check1("timeout_still_draining", quiescence_resp.data[1:0], 2'b10);
    step(0, 1, 1, 0, 0, 0, 0);
    idle();
    check1("resume_after_timeout", quiescence_resp.data, 64'h10000);
    check1("resume_running", quiesced, 1'b0);
    step(0, 0, 0, 0, 0, 0, 1);

    // Underflow while quiesced, then reset clears everything.
    step(0, 1, 1, 1, 0, 0, 0);
    idle();
    check1("uf_seq_quiesced", quiesced, 1'b1);
    step(0, 0, 0, 0, 0, 0, 1);
    idle();
    check1("uf_flag_set", quiescence_resp.data, 64'h9);
    check1("uf_stays_quiesced", quiesced, 1'b1);
    step(1, 0, 0, 0, 0, 0, 0);
    check1("uf_reset_quiesced", quiesced, 1'b0);
    check1("uf_reset_data", quiescence_resp.data, 64'h0);

    // Reset in the middle of a drain with a response landing during reset.
    step(0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 1, 1, 0);
    step(0, 1, 1, 1, 0, 0, 0);
    idle();
    step(1, 0, 0, 0, 0, 0, 1);
    idle();
    idle();
    check1("mid_drain_reset", quiescence_resp.data, 64'h0);

    for (int n = 0; n < 800; n++) begin
      r     = ($urandom_range(0, 99) == 0);
      rv    = ($urandom_range(0, 9) == 0);
      isreq = ($urandom_range(0, 3) != 0);
      cbit  = $urandom_range(0, 1);
      av    = $urandom_range(0, 1);
      g     = ($urandom_range(0, 3) != 0);
      resp  = ($urandom_range(0, 2) == 0);
      if (rv && isreq && !cbit) resp = 0;
      step(r, rv, isreq, cbit, av, g, resp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
